// File: rtl/action_judge.sv
// action_judge: shared scoring stage between the button debouncers and the
// display/LED logic. Each action window runs from one step_strobe to the next.
// The first button press in a window is captured and compared with the
// expected action nibble. The block keeps running hit and wrong counts and
// raises a sticky game_over once the wrong count reaches MAX_WRONG.
//
// Optional feature: define JUDGE_EARLY_FAIL_EN to score a wrong press
// immediately. By default, every window is scored only when it closes.
module action_judge #(
  parameter int MAX_WRONG = 3,
  parameter int STEPS     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       step_strobe,
  input  logic [3:0] action,
  input  logic [3:0] btn,
  output logic [3:0] operation,
  output logic [2:0] wrong_cnt,
  output logic [3:0] hit_cnt,
  output logic       result_valid,
  output logic       result_ok,
  output logic       level_clear,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [3:0] btn_q;
  logic [3:0] rise;
  logic [3:0] expect_vec;
  logic [3:0] captured;
  logic       window_ok;
  logic [2:0] wrong_inc;
  logic       hit_wrap;

  logic       scored;
  logic       scored_next;
  logic       score_now;
  logic       score_ok;

  logic [3:0] operation_next;
  logic [2:0] wrong_next;
  logic [3:0] hit_next;
  logic       valid_next;
  logic       ok_next;
  logic       clear_next;
  logic       over_next;

  // Button edges: a held button produces exactly one rise, in its first cycle.
  assign rise = btn & ~btn_q;

  // The only correct press is the one-hot bit of a real action. Actions 4..15
  // mean "stay still", so the only correct capture there is no press at all.
  // This makes multi-bit presses mismatch automatically.
  assign expect_vec = (action < 4'd4) ? (4'b0001 << action[1:0]) : 4'b0000;

  // While still ARMED, a rise in the closing cycle belongs to the window.
  // Once HELD, the latched press is what gets judged.
  assign captured  = (state == ARMED) ? rise : operation;
  assign window_ok = (captured == expect_vec);

  assign wrong_inc = (wrong_cnt < 3'(MAX_WRONG)) ? (wrong_cnt + 3'd1) : wrong_cnt;
  assign hit_wrap  = (hit_cnt == 4'(STEPS - 1));

  // Previous button levels, sampled every cycle regardless of the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 4'd0;
    end else begin
      btn_q <= btn;
    end
  end

  // State and all result registers advance together from the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      scored       <= 1'b0;
      operation    <= 4'd0;
      wrong_cnt    <= 3'd0;
      hit_cnt      <= 4'd0;
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
      level_clear  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_next;
      scored       <= scored_next;
      operation    <= operation_next;
      wrong_cnt    <= wrong_next;
      hit_cnt      <= hit_next;
      result_valid <= valid_next;
      result_ok    <= ok_next;
      level_clear  <= clear_next;
      game_over    <= over_next;
    end
  end

  // Window sequencing and scoring. Pulses default low; everything else holds.
  always_comb begin
    state_next     = state;
    scored_next    = scored;
    operation_next = operation;
    wrong_next     = wrong_cnt;
    hit_next       = hit_cnt;
    valid_next     = 1'b0;
    ok_next        = result_ok;
    clear_next     = 1'b0;
    over_next      = game_over;
    score_now      = 1'b0;
    score_ok       = 1'b0;

    case (state)
      IDLE: begin
        // A new level always starts from zero hits. wrong_cnt is game-wide.
        if (enable) begin
          state_next     = ARMED;
          hit_next       = 4'd0;
          operation_next = 4'd0;
          scored_next    = 1'b0;
        end
      end

      ARMED, HELD: begin
        if (!enable) begin
          // Level paused mid-window: drop the window without a verdict.
          state_next     = IDLE;
          operation_next = 4'd0;
          scored_next    = 1'b0;
        end else if (step_strobe) begin
          // Close the window and open the next one with a clean capture.
          state_next     = ARMED;
          operation_next = 4'd0;
          scored_next    = 1'b0;
          if (!scored) begin
            score_now = 1'b1;
            score_ok  = window_ok;
          end
        end else if ((state == ARMED) && (rise != 4'd0)) begin
          operation_next = rise;
          state_next     = HELD;
`ifdef JUDGE_EARLY_FAIL_EN
          // A wrong first press cannot become right later, so judge it now
          // and remember that this window already has its verdict.
          if (rise != expect_vec) begin
            score_now   = 1'b1;
            score_ok    = 1'b0;
            scored_next = 1'b1;
          end
`endif
        end
      end

      OVER: begin
        // Frozen until reset. result_valid and level_clear fall via defaults.
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (score_now) begin
      valid_next = 1'b1;
      ok_next    = score_ok;
      if (score_ok) begin
        if (hit_wrap) begin
          hit_next   = 4'd0;
          clear_next = 1'b1;
        end else begin
          hit_next = hit_cnt + 4'd1;
        end
      end else begin
        wrong_next = wrong_inc;
        if (wrong_inc == 3'(MAX_WRONG)) begin
          state_next  = OVER;
          over_next   = 1'b1;
          scored_next = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_action_judge.sv
// Testbench for action_judge: directed scenarios followed by random traffic,
// all checked cycle by cycle against a window-level reference model.
module tb_action_judge;

  localparam int MAX_WRONG = 3;
  localparam int STEPS     = 15;
`ifdef JUDGE_EARLY_FAIL_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       enable;
  logic       step_strobe;
  logic [3:0] action;
  logic [3:0] btn;
  logic [3:0] operation;
  logic [2:0] wrong_cnt;
  logic [3:0] hit_cnt;
  logic       result_valid;
  logic       result_ok;
  logic       level_clear;
  logic       game_over;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: a game is a sequence of windows. Within a window only the
  // first press counts, and each window gets at most one verdict.
  bit         m_active;
  bit         m_over;
  bit         m_early;
  logic [3:0] m_first;
  logic [3:0] m_prev;
  int         m_hit;
  int         m_wrong;
  bit         m_rv;
  bit         m_ok;
  bit         m_lc;

  action_judge #(
    .MAX_WRONG(MAX_WRONG),
    .STEPS    (STEPS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .step_strobe (step_strobe),
    .action      (action),
    .btn         (btn),
    .operation   (operation),
    .wrong_cnt   (wrong_cnt),
    .hit_cnt     (hit_cnt),
    .result_valid(result_valid),
    .result_ok   (result_ok),
    .level_clear (level_clear),
    .game_over   (game_over)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_active = 1'b0;
    m_over   = 1'b0;
    m_early  = 1'b0;
    m_first  = 4'd0;
    m_prev   = 4'd0;
    m_hit    = 0;
    m_wrong  = 0;
    m_rv     = 1'b0;
    m_ok     = 1'b0;
    m_lc     = 1'b0;
  endtask

  task automatic modelScore(input bit ok);
    m_rv = 1'b1;
    m_ok = ok;
    if (ok) begin
      m_hit = m_hit + 1;
      if (m_hit == STEPS) begin
        m_hit = 0;
        m_lc  = 1'b1;
      end
    end else begin
      if (m_wrong < MAX_WRONG) m_wrong = m_wrong + 1;
      if (m_wrong == MAX_WRONG) m_over = 1'b1;
    end
  endtask

  task automatic modelStep(input logic en, input logic st, input logic [3:0] act,
                           input logic [3:0] bt);
    logic [3:0] rise;
    logic [3:0] want;
    bit         fresh;
    rise   = bt & ~m_prev;
    m_prev = bt;
    m_rv   = 1'b0;
    m_lc   = 1'b0;
    if (m_over) return;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_hit    = 0;
      end
      return;
    end
    if (!en) begin
      m_active = 1'b0;
      m_first  = 4'd0;
      m_early  = 1'b0;
      return;
    end
    want  = (act < 4'd4) ? 4'(1 << act) : 4'd0;
    fresh = 1'b0;
    if ((m_first == 4'd0) && (rise != 4'd0)) begin
      m_first = rise;
      fresh   = 1'b1;
    end
    if (st) begin
      if (!m_early) modelScore(m_first == want);
      m_first = 4'd0;
      m_early = 1'b0;
    end else if (EARLY && fresh && (m_first != want)) begin
      modelScore(1'b0);
      m_early = 1'b1;
    end
  endtask

  task automatic checkOutput();
    checkVal("operation",    8'(operation),    8'(m_first));
    checkVal("wrong_cnt",    8'(wrong_cnt),    8'(m_wrong));
    checkVal("hit_cnt",      8'(hit_cnt),      8'(m_hit));
    checkVal("result_valid", 8'(result_valid), 8'(m_rv));
    checkVal("result_ok",    8'(result_ok),    8'(m_ok));
    checkVal("level_clear",  8'(level_clear),  8'(m_lc));
    checkVal("game_over",    8'(game_over),    8'(m_over));
  endtask

  task automatic applyStimulus(input logic en, input logic st, input logic [3:0] act,
                               input logic [3:0] bt);
    @(negedge clk);
    enable      = en;
    step_strobe = st;
    action      = act;
    btn         = bt;
    modelStep(en, st, act, bt);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    enable      = 1'b0;
    step_strobe = 1'b0;
    action      = 4'd0;
    btn         = 4'd0;
    rst         = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r_act;
    logic [3:0] r_btn;
    logic       r_en;
    logic       r_st;

    rst         = 1'b1;
    enable      = 1'b0;
    step_strobe = 1'b0;
    action      = 4'd0;
    btn         = 4'd0;
    modelReset();
    $display("[TB] start, EARLY=%0d", EARLY);

    // Scenario 1: correct press then strobe scores a hit.
    doReset();
    applyStimulus(1, 0, 4'd2, 4'b0000);
    applyStimulus(1, 0, 4'd2, 4'b0100);
    applyStimulus(1, 1, 4'd2, 4'b0100);
    checkVal("s1_valid", 8'(result_valid), 8'd1);
    checkVal("s1_ok",    8'(result_ok),    8'd1);
    checkVal("s1_hit",   8'(hit_cnt),      8'd1);
    checkVal("s1_op",    8'(operation),    8'd0);
    applyStimulus(1, 0, 4'd2, 4'b0000);

    // Scenario 2: three silent windows end the game; a fourth strobe is ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 4'd0, 4'b0000);
      checkVal("s2_wrong", 8'(wrong_cnt), 8'(i + 1));
    end
    checkVal("s2_over", 8'(game_over), 8'd1);
    applyStimulus(1, 1, 4'd0, 4'b0000);
    checkVal("s2_no_result", 8'(result_valid), 8'd0);

    // Scenario 3: second press in a window is ignored.
    doReset();
    applyStimulus(1, 0, 4'd1, 4'b0000);
    applyStimulus(1, 0, 4'd1, 4'b0010);
    applyStimulus(1, 0, 4'd1, 4'b1010);
    checkVal("s3_op", 8'(operation), 8'h02);
    applyStimulus(1, 1, 4'd1, 4'b1010);
    checkVal("s3_ok", 8'(result_ok), 8'd1);
    applyStimulus(1, 0, 4'd1, 4'b0000);

    // Scenario 4: press coinciding with the strobe; then a two-button press.
    applyStimulus(1, 1, 4'd3, 4'b1000);
    checkVal("s4_same_cycle_ok", 8'(result_ok), 8'd1);
    applyStimulus(1, 0, 4'd3, 4'b0000);
    applyStimulus(1, 1, 4'd3, 4'b1001);
    checkVal("s4_multi_ok",    8'(result_ok), 8'd0);
    checkVal("s4_multi_wrong", 8'(wrong_cnt), 8'd1);
    applyStimulus(1, 0, 4'd3, 4'b0000);

    // Scenario 5: a full level of hits, then a pause and resume.
    doReset();
    applyStimulus(1, 0, 4'd0, 4'b0000);
    applyStimulus(1, 1, 4'd0, 4'b0000);
    for (int i = 0; i < STEPS; i++) begin
      applyStimulus(1, 0, 4'(i % 4), 4'b0000);
      applyStimulus(1, 1, 4'(i % 4), 4'(1 << (i % 4)));
    end
    checkVal("s5_clear", 8'(level_clear), 8'd1);
    checkVal("s5_wrap",  8'(hit_cnt),     8'd0);
    applyStimulus(1, 0, 4'd1, 4'b0000);
    applyStimulus(1, 1, 4'd1, 4'b0010);
    applyStimulus(1, 0, 4'd0, 4'b0000);
    applyStimulus(1, 0, 4'd0, 4'b0001);
    applyStimulus(0, 1, 4'd0, 4'b0001);
    checkVal("s5_drop_valid", 8'(result_valid), 8'd0);
    checkVal("s5_drop_op",    8'(operation),    8'd0);
    checkVal("s5_drop_hit",   8'(hit_cnt),      8'd1);
    applyStimulus(1, 0, 4'd0, 4'b0000);
    checkVal("s5_resume_hit",   8'(hit_cnt),   8'd0);
    checkVal("s5_resume_wrong", 8'(wrong_cnt), 8'd1);

`ifdef JUDGE_EARLY_FAIL_EN
    // Scenario 6: a wrong press is judged at once; its strobe adds nothing.
    doReset();
    applyStimulus(1, 0, 4'd0, 4'b0000);
    applyStimulus(1, 0, 4'd0, 4'b0100);
    checkVal("s6_early_valid", 8'(result_valid), 8'd1);
    checkVal("s6_early_ok",    8'(result_ok),    8'd0);
    applyStimulus(1, 1, 4'd0, 4'b0100);
    checkVal("s6_strobe_valid", 8'(result_valid), 8'd0);
`endif

    // Random traffic with occasional pauses and resets.
    doReset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      r_en  = ($urandom_range(0, 29) != 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_act = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       r_btn = btn;
        1:       r_btn = 4'd0;
        2:       r_btn = 4'(1 << $urandom_range(0, 3));
        3:       r_btn = 4'($urandom_range(0, 15));
        default: r_btn = (r_act < 4'd4) ? 4'(1 << r_act) : 4'd0;
      endcase
      applyStimulus(r_en, r_st, r_act, r_btn);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
